vga_frame_reader: RTL and testbench

//  Parametrised framebuffer scan-out stage between vga_controller and the

---
 rtl/vga_pkg.sv | 51 +++++
 rtl/vga_sync_delay.sv | 43 ++++
 rtl/vga_frame_reader.sv | 170 +++++++++++++++++
 tb/tb_vga_frame_reader.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions for the frame reader slice.
//   - 640x480@60 timing constants (active area, porches, sync widths)
//   - rgb888_t : one output pixel, 8 bits per channel
//   - pix_expand() : widen a 24/16/12/8-bit memory word to RGB888
package vga_pkg;

  localparam int unsigned H_ACTIVE = 32'd640;
  localparam int unsigned H_FRONT  = 32'd16;
  localparam int unsigned H_SYNC   = 32'd96;
  localparam int unsigned H_BACK   = 32'd48;
  localparam int unsigned V_ACTIVE = 32'd480;
  localparam int unsigned V_FRONT  = 32'd10;
  localparam int unsigned V_SYNC   = 32'd2;
  localparam int unsigned V_BACK   = 32'd33;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Channels are widened by repeating their MSBs into the low bits so that
  // full scale maps to 8'hFF and zero stays 8'h00.
  function automatic rgb888_t pix_expand(input int unsigned pix_w, input logic [23:0] data);
    rgb888_t v_rgb;
    case (pix_w)
      32'd16: begin
        v_rgb.r = {data[15:11], data[15:13]};
        v_rgb.g = {data[10:5],  data[10:9]};
        v_rgb.b = {data[4:0],   data[4:2]};
      end
      32'd12: begin
        v_rgb.r = {data[11:8], data[11:8]};
        v_rgb.g = {data[7:4],  data[7:4]};
        v_rgb.b = {data[3:0],  data[3:0]};
      end
      32'd8: begin
        v_rgb.r = {data[7:5], data[7:5], data[7:6]};
        v_rgb.g = {data[4:2], data[4:2], data[4:3]};
        v_rgb.b = {data[1:0], data[1:0], data[1:0], data[1:0]};
      end
      default: begin
        v_rgb.r = data[23:16];
        v_rgb.g = data[15:8];
        v_rgb.b = data[7:0];
      end
    endcase
    return v_rgb;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Fixed-depth shift register used to keep per-pixel flags aligned with the
// memory read path.
//   i_clk    : clock
//   i_n_rst  : synchronous active-low reset, all stages load RST_VAL
//   i_data   : flags entering the pipe
//   o_data   : flags after DEPTH cycles
//   o_tap    : flags after DEPTH-1 cycles (feeds logic that is itself registered)
module vga_sync_delay #(
  parameter int unsigned     WIDTH   = 32'd4,
  parameter int unsigned     DEPTH   = 32'd3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_n_rst,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic [WIDTH-1:0] o_tap
);

  if (DEPTH < 32'd2) begin : g_bad_depth
    $error("vga_sync_delay: DEPTH must be at least 2");
  end

  logic [WIDTH-1:0] r_stage [DEPTH];

  // Shift the flags one stage per clock; reset loads every stage.
  always_ff @(posedge i_clk) begin
    if (!i_n_rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_stage[i] <= RST_VAL;
      end
    end else begin
      r_stage[0] <= i_data;
      for (int i = 1; i < int'(DEPTH); i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_data = r_stage[DEPTH-1];
  assign o_tap  = r_stage[DEPTH-2];

endmodule

// File: rtl/vga_frame_reader.sv
// Framebuffer scan-out: turns the controller's x/y raster into pixel memory
// addresses (incremental counters, integer upscale, X/Y offset), delays the
// sync/blank flags by the read latency and drives RGB888.
//   clk_25, n_rst          : pixel clock, synchronous active-low reset
//   in_hsync/vsync/video_on: controller timing flags
//   in_x, in_y             : current raster position
//   mem_addr / mem_q       : registered read address, data MEM_LAT cycles later
//   out_hsync/vsync/blank_n: inputs delayed by MEM_LAT+2
//   out_r/g/b              : pixel colour, same latency
module vga_frame_reader #(
  parameter int unsigned H_ACTIVE   = vga_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE   = vga_pkg::V_ACTIVE,
  parameter int unsigned IMG_W      = 32'd320,
  parameter int unsigned IMG_H      = 32'd240,
  parameter int unsigned SCALE      = 32'd2,
  parameter int unsigned X_OFF      = 32'd0,
  parameter int unsigned Y_OFF      = 32'd0,
  parameter int unsigned PIX_W      = 32'd24,
  parameter int unsigned MEM_LAT    = 32'd1,
  parameter int unsigned ADDR_W     = $clog2(IMG_W*IMG_H),
  parameter logic [23:0] BORDER_RGB = 24'h000000
) (
  input  logic              clk_25,
  input  logic              n_rst,
  input  logic              in_hsync,
  input  logic              in_vsync,
  input  logic              in_video_on,
  input  logic [9:0]        in_x,
  input  logic [9:0]        in_y,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_q,
  output logic              out_hsync,
  output logic              out_vsync,
  output logic              out_blank_n,
  output logic [7:0]        out_r,
  output logic [7:0]        out_g,
  output logic [7:0]        out_b
);
  import vga_pkg::*;

  if (SCALE < 32'd1) begin : g_bad_scale
    $error("vga_frame_reader: SCALE must be >= 1");
  end
  if (MEM_LAT < 32'd1) begin : g_bad_lat
    $error("vga_frame_reader: MEM_LAT must be >= 1");
  end
  if (X_OFF + IMG_W*SCALE > H_ACTIVE || H_ACTIVE > 32'd1024) begin : g_bad_x
    $error("vga_frame_reader: image does not fit horizontally");
  end
  if (Y_OFF + IMG_H*SCALE > V_ACTIVE || V_ACTIVE > 32'd1024) begin : g_bad_y
    $error("vga_frame_reader: image does not fit vertically");
  end
  if (PIX_W != 32'd24 && PIX_W != 32'd16 && PIX_W != 32'd12 && PIX_W != 32'd8) begin : g_bad_pix
    $error("vga_frame_reader: PIX_W must be 24, 16, 12 or 8");
  end

  localparam int unsigned      SUB_W    = (SCALE > 32'd1) ? $clog2(SCALE) : 32'd1;
  localparam logic [SUB_W-1:0] SUB_MAX  = SUB_W'(SCALE - 32'd1);
  localparam logic [10:0]      X_LO     = 11'(X_OFF);
  localparam logic [10:0]      Y_LO     = 11'(Y_OFF);
  localparam logic [10:0]      X_SPAN   = 11'(IMG_W*SCALE);
  localparam logic [10:0]      Y_SPAN   = 11'(IMG_H*SCALE);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

  // Offsets into the window; positions left of/above it wrap to values far
  // above the span, so one unsigned compare covers both window edges.
  logic [10:0] w_dx;
  logic [10:0] w_dy;
  logic        w_in_y;
  logic        w_in_img;
  logic        w_last_col;

  assign w_dx       = {1'b0, in_x} - X_LO;
  assign w_dy       = {1'b0, in_y} - Y_LO;
  assign w_in_y     = (w_dy < Y_SPAN);
  assign w_in_img   = w_in_y && (w_dx < X_SPAN);
  assign w_last_col = (w_dx == (X_SPAN - 11'd1));

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_row_base;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [SUB_W-1:0]  r_col_sub;
  logic [SUB_W-1:0]  r_row_sub;

  // Address generation: r_addr always holds the word for the current pixel,
  // so it is registered out before being advanced.
  always_ff @(posedge clk_25) begin
    if (!n_rst) begin
      r_mem_addr <= {ADDR_W{1'b0}};
      r_addr     <= {ADDR_W{1'b0}};
      r_row_base <= {ADDR_W{1'b0}};
      r_col_sub  <= {SUB_W{1'b0}};
      r_row_sub  <= {SUB_W{1'b0}};
    end else begin
      r_mem_addr <= r_addr;
      if (!w_in_y) begin
        // Outside the vertical window the counters rest at zero: frame wrap.
        r_addr     <= {ADDR_W{1'b0}};
        r_row_base <= {ADDR_W{1'b0}};
        r_col_sub  <= {SUB_W{1'b0}};
        r_row_sub  <= {SUB_W{1'b0}};
      end else if (w_in_img && w_last_col) begin
        r_col_sub <= {SUB_W{1'b0}};
        if (r_row_sub == SUB_MAX) begin
          r_row_sub  <= {SUB_W{1'b0}};
          r_row_base <= r_row_base + ROW_STEP;
          r_addr     <= r_row_base + ROW_STEP;
        end else begin
          // Same source line again for the next SCALE-1 screen lines.
          r_row_sub <= r_row_sub + SUB_W'(1);
          r_addr    <= r_row_base;
        end
      end else if (w_in_img) begin
        if (r_col_sub == SUB_MAX) begin
          r_col_sub <= {SUB_W{1'b0}};
          r_addr    <= r_addr + ADDR_W'(1);
        end else begin
          r_col_sub <= r_col_sub + SUB_W'(1);
        end
      end else begin
        r_addr <= r_addr;
      end
    end
  end

  assign mem_addr = r_mem_addr;

  // Flags: [3] hsync, [2] vsync, [1] video_on, [0] in_img.
  logic [3:0] w_dly_out;
  logic [3:0] w_dly_tap;

  vga_sync_delay #(
    .WIDTH   (32'd4),
    .DEPTH   (MEM_LAT + 32'd2),
    .RST_VAL (4'b1100)
  ) u_sync_delay (
    .i_clk   (clk_25),
    .i_n_rst (n_rst),
    .i_data  ({in_hsync, in_vsync, in_video_on, w_in_img}),
    .o_data  (w_dly_out),
    .o_tap   (w_dly_tap)
  );

  logic [23:0] w_q24;
  rgb888_t     r_rgb;

  assign w_q24 = 24'(mem_q);

  // Output colour register; the tap is one stage short because this register
  // supplies the final cycle of latency, lining up with mem_q.
  always_ff @(posedge clk_25) begin
    if (!n_rst) begin
      r_rgb <= 24'h000000;
    end else if (!w_dly_tap[1]) begin
      r_rgb <= 24'h000000;
    end else if (!w_dly_tap[0]) begin
      r_rgb <= BORDER_RGB;
    end else begin
      r_rgb <= pix_expand(PIX_W, w_q24);
    end
  end

  assign out_hsync   = w_dly_out[3];
  assign out_vsync   = w_dly_out[2];
  assign out_blank_n = w_dly_out[1];
  assign out_r       = r_rgb.r;
  assign out_g       = r_rgb.g;
  assign out_b       = r_rgb.b;

endmodule

// File: tb/tb_vga_frame_reader.sv
module tb_vga_frame_reader;

  typedef struct {
    int xo; int yo; int w; int h; int s; int pixw; int lat;
    logic [23:0] border;
  } cfg_t;

  typedef struct {
    logic rst; logic hs; logic vs; logic vid; logic img; logic chk;
    int addr; logic [23:0] rgb;
  } exp_t;

  typedef struct {
    logic [11:0] q; logic vid; int x; logic [23:0] rgb;
  } vec_t;

  localparam cfg_t CA = '{xo: 0,  yo: 0, w: 320, h: 240, s: 2, pixw: 24, lat: 1, border: 24'h000000};
  localparam cfg_t CB = '{xo: 64, yo: 2, w: 256, h: 8,   s: 2, pixw: 12, lat: 2, border: 24'h123456};

  logic clk;
  logic n_rst, hsync, vsync, video_on;
  logic [9:0] x_s, y_s;

  logic [16:0] a_addr;  logic [23:0] a_q;
  logic a_hs, a_vs, a_bl; logic [7:0] a_r, a_g, a_b;
  logic [10:0] b_addr;  logic [11:0] b_q1, b_q;
  logic b_hs, b_vs, b_bl; logic [7:0] b_r, b_g, b_b;

  logic        ovr_en;
  logic [11:0] ovr_data;
  logic [31:0] seed;

  int n_chk, n_pass;
  bit va, vb;
  exp_t qa[$], qb[$];

  vga_frame_reader u_a (
    .clk_25(clk), .n_rst(n_rst), .in_hsync(hsync), .in_vsync(vsync),
    .in_video_on(video_on), .in_x(x_s), .in_y(y_s), .mem_addr(a_addr), .mem_q(a_q),
    .out_hsync(a_hs), .out_vsync(a_vs), .out_blank_n(a_bl),
    .out_r(a_r), .out_g(a_g), .out_b(a_b));

  vga_frame_reader #(
    .H_ACTIVE(640), .V_ACTIVE(20), .IMG_W(256), .IMG_H(8), .SCALE(2),
    .X_OFF(64), .Y_OFF(2), .PIX_W(12), .MEM_LAT(2), .BORDER_RGB(24'h123456)
  ) u_b (
    .clk_25(clk), .n_rst(n_rst), .in_hsync(hsync), .in_vsync(vsync),
    .in_video_on(video_on), .in_x(x_s), .in_y(y_s), .mem_addr(b_addr), .mem_q(b_q),
    .out_hsync(b_hs), .out_vsync(b_vs), .out_blank_n(b_bl),
    .out_r(b_r), .out_g(b_g), .out_b(b_b));

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  // Memory contents: a scrambled function of the address.
  function automatic logic [23:0] dfun(input int addr, input int pixw);
    logic [31:0] h;
    h = (32'(addr) * 32'h9E3779B1) ^ seed;
    h = h ^ (h >> 13);
    if (pixw == 12) return {12'h000, h[11:0]};
    else return h[23:0];
  endfunction

  // Memory models: A reads in 1 cycle, B in 2.
  always @(posedge clk) a_q <= dfun(int'(a_addr), 24);
  always @(posedge clk) begin
    b_q1 <= ovr_en ? ovr_data : 12'(dfun(int'(b_addr), 12));
    b_q  <= b_q1;
  end

  function automatic logic [23:0] expand_ref(input int pixw, input logic [23:0] d);
    int r, g, b;
    if (pixw == 12) begin
      r = int'(d[11:8]); g = int'(d[7:4]); b = int'(d[3:0]);
      return {8'(r * 17), 8'(g * 17), 8'(b * 17)};
    end
    return d;
  endfunction

  function automatic exp_t mk(input cfg_t c, input bit valid, input int x, input int y,
                              input logic hs, input logic vs, input logic vid);
    exp_t e;
    e.rst = 1'b0; e.hs = hs; e.vs = vs; e.vid = vid; e.chk = valid;
    e.img = (x >= c.xo) && (x < c.xo + c.w * c.s) && (y >= c.yo) && (y < c.yo + c.h * c.s);
    e.addr = 0;
    e.rgb = c.border;
    if (e.img) begin
      e.addr = ((y - c.yo) / c.s) * c.w + (x - c.xo) / c.s;
      e.rgb  = expand_ref(c.pixw, dfun(e.addr, c.pixw));
    end
    return e;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (x=%0d y=%0d t=%0t)", name, act, exp, x_s, y_s, $time);
  endtask

  task automatic cmp_out(input string tag, input exp_t f, input logic hs, input logic vs,
                         input logic bl, input logic [23:0] rgb, input logic [23:0] border);
    cmp({tag, "_hsync"}, 32'(hs), f.rst ? 32'd1 : 32'(f.hs));
    cmp({tag, "_vsync"}, 32'(vs), f.rst ? 32'd1 : 32'(f.vs));
    cmp({tag, "_blank_n"}, 32'(bl), f.rst ? 32'd0 : 32'(f.vid));
    if (f.rst || !f.vid) cmp({tag, "_rgb_off"}, 32'(rgb), 32'd0);
    else if (!f.img) cmp({tag, "_rgb_border"}, 32'(rgb), 32'(border));
    else if (f.chk) cmp({tag, "_rgb_pix"}, 32'(rgb), 32'(f.rgb));
  endtask

  task automatic cmp_addr(input string tag, input exp_t e, input int act);
    if (e.rst) cmp({tag, "_addr_rst"}, 32'(act), 32'd0);
    else if (e.img && e.chk) cmp({tag, "_addr"}, 32'(act), 32'(e.addr));
  endtask

  // One pixel clock: drive inputs, advance, check address and delayed outputs.
  task automatic step(input logic rst, input int x, input int y,
                      input logic hs, input logic vs, input logic vid);
    exp_t ea, eb, r0;
    n_rst = ~rst; x_s = 10'(x); y_s = 10'(y);
    hsync = hs; vsync = vs; video_on = vid;
    if (y >= 480) va = 1'b1;
    if (y < 2 || y >= 18) vb = 1'b1;
    ea = mk(CA, va, x, y, hs, vs, vid);
    eb = mk(CB, vb, x, y, hs, vs, vid);
    if (rst) begin
      r0 = '{rst: 1'b1, hs: 1'b1, vs: 1'b1, vid: 1'b0, img: 1'b0, chk: 1'b0, addr: 0, rgb: 24'h0};
      ea = r0; eb = r0;
      va = 1'b0; vb = 1'b0;
      qa.delete(); qb.delete();
      for (int i = 0; i < CA.lat + 2; i++) qa.push_back(r0);
      for (int i = 0; i < CB.lat + 2; i++) qb.push_back(r0);
    end else begin
      qa.push_back(ea);
      qb.push_back(eb);
    end
    @(posedge clk); #1;
    cmp_addr("a", ea, int'(a_addr));
    cmp_addr("b", eb, int'(b_addr));
    if (qa.size() >= CA.lat + 2) cmp_out("a", qa.pop_front(), a_hs, a_vs, a_bl, {a_r, a_g, a_b}, CA.border);
    if (qb.size() >= CB.lat + 2) cmp_out("b", qb.pop_front(), b_hs, b_vs, b_bl, {b_r, b_g, b_b}, CB.border);
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) step(1'b0, i, 500, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
  endtask

  vec_t tbl[8];
  int   a_seq[8];

  initial begin
    int px, py;
    logic rst_v;
    tbl[0] = '{q: 12'hF80, vid: 1'b1, x: 100, rgb: 24'hFF8800};
    tbl[1] = '{q: 12'h0F0, vid: 1'b1, x: 300, rgb: 24'h00FF00};
    tbl[2] = '{q: 12'h5A3, vid: 1'b1, x: 575, rgb: 24'h55AA33};
    tbl[3] = '{q: 12'hF80, vid: 1'b0, x: 100, rgb: 24'h000000};
    tbl[4] = '{q: 12'hABC, vid: 1'b1, x: 63,  rgb: 24'h123456};
    tbl[5] = '{q: 12'hABC, vid: 1'b1, x: 576, rgb: 24'h123456};
    tbl[6] = '{q: 12'h08F, vid: 1'b1, x: 64,  rgb: 24'h0088FF};
    tbl[7] = '{q: 12'hABC, vid: 1'b0, x: 10,  rgb: 24'h000000};
    a_seq = '{0, 0, 1, 1, 2, 2, 3, 3};

    n_chk = 0; n_pass = 0; va = 1'b0; vb = 1'b0;
    seed = $urandom;
    ovr_en = 1'b0; ovr_data = 12'h000;
    n_rst = 1'b0; hsync = 1'b1; vsync = 1'b1; video_on = 1'b0; x_s = 10'd0; y_s = 10'd0;

    // Reset held mid-line.
    for (int i = 0; i < 3; i++) step(1'b1, 200 + i, 50, 1'b0, 1'b0, 1'b1);
    cmp("rst_a_addr", 32'(a_addr), 32'd0);
    cmp("rst_b_rgb", 32'({b_r, b_g, b_b}), 32'd0);
    blank(8);

    // Single hsync pulse: A shows it 3 cycles later, B 4 cycles later.
    for (int i = 0; i < 4; i++) step(1'b0, i, 500, 1'b1, 1'b1, 1'b0);
    step(1'b0, 4, 500, 1'b0, 1'b1, 1'b0);
    step(1'b0, 5, 500, 1'b1, 1'b1, 1'b0);
    step(1'b0, 6, 500, 1'b1, 1'b1, 1'b0);
    cmp("hs_pulse_a_t3", 32'(a_hs), 32'd0);
    cmp("hs_pulse_b_t3", 32'(b_hs), 32'd1);
    step(1'b0, 7, 500, 1'b1, 1'b1, 1'b0);
    cmp("hs_pulse_a_t4", 32'(a_hs), 32'd1);
    cmp("hs_pulse_b_t4", 32'(b_hs), 32'd0);

    // Pixel-format and border table on B with forced memory data.
    va = 1'b0; vb = 1'b0;
    ovr_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      ovr_data = tbl[k].q;
      for (int i = 0; i < 6; i++) step(1'b0, tbl[k].x, 4, 1'b1, 1'b1, tbl[k].vid);
      cmp("tbl_rgb", 32'({b_r, b_g, b_b}), 32'(tbl[k].rgb));
      cmp("tbl_blank_n", 32'(b_bl), 32'(tbl[k].vid));
    end
    ovr_en = 1'b0;
    blank(8);

    // Three frames of random sync/blank; reset in the middle of frame 2.
    for (int f = 0; f < 3; f++) begin
      for (py = 0; py < 20; py++) begin
        for (px = 0; px < 640; px++) begin
          rst_v = (f == 1 && py == 5 && px >= 300 && px < 303);
          step(rst_v, px, py, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 7) != 0));
          if (f != 1) begin
            if (py == 0 && px < 8) cmp("a_first_line", 32'(a_addr), 32'(a_seq[px]));
            if (py == 1 && px == 639) cmp("a_line1_end", 32'(a_addr), 32'd319);
            if (py == 2 && px == 0) cmp("a_line2_start", 32'(a_addr), 32'd320);
            if (py == 2 && px == 64) cmp("b_first_pix", 32'(b_addr), 32'd0);
            if (py == 17 && px == 575) cmp("b_last_pix", 32'(b_addr), 32'd2047);
          end
          if (rst_v) begin
            cmp("midrst_a_addr", 32'(a_addr), 32'd0);
            cmp("midrst_b_hs", 32'(b_hs), 32'd1);
          end
        end
      end
      blank(8);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
